// File: rtl/jump_key_conditioner.sv
// Push-button conditioner: synchronizes and debounces raw_key, then holds each accepted
// press as a pending flag until the interrupt controller consumes it.
module jump_key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned MISS_W          = 8
) (
    input  logic              proc_clk,
    input  logic              reset,
    input  logic              raw_key,
    input  logic              key_consume,
    output logic              jump_key,
    output logic              key_level,
    output logic [MISS_W-1:0] missed_presses
);

    typedef enum logic [1:0] {
        IDLE_UP,
        WAIT_DOWN,
        HELD_DOWN,
        WAIT_UP
    } state_t;

    localparam logic [23:0]       CNT_LAST = 24'(DEBOUNCE_CYCLES - 1);
    localparam logic [MISS_W-1:0] MISS_MAX = '1;
    localparam logic [MISS_W-1:0] MISS_ONE = MISS_W'(1);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    state_t            state_q, state_d;
    logic [23:0]       cnt_q, cnt_d;
    logic              pending_q, pending_d;
    logic              key_level_q, key_level_d;
    logic [MISS_W-1:0] missed_q, missed_d;
    logic              press;

    always_comb begin
        sync1_d     = raw_key;
        sync2_d     = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        press       = 1'b0;

        case (state_q)
            IDLE_UP: begin
                if (sync2_q) begin
                    state_d = WAIT_DOWN;
                    cnt_d   = '0;
                end
            end
            WAIT_DOWN: begin
                if (!sync2_q) begin
                    state_d = IDLE_UP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD_DOWN;
                    press   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            HELD_DOWN: begin
                if (!sync2_q) begin
                    state_d = WAIT_UP;
                    cnt_d   = '0;
                end
            end
            WAIT_UP: begin
                if (sync2_q) begin
                    state_d = HELD_DOWN;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_UP;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            default: state_d = IDLE_UP;
        endcase

        key_level_d = (state_d == HELD_DOWN) || (state_d == WAIT_UP);

        // A press landing on the consume edge re-arms pending and is not counted as missed.
        missed_d  = missed_q;
        pending_d = pending_q;
        if (press) begin
            pending_d = 1'b1;
            if (pending_q && !key_consume && (missed_q != MISS_MAX))
                missed_d = missed_q + MISS_ONE;
        end else if (key_consume) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge proc_clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= IDLE_UP;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            key_level_q <= 1'b0;
            missed_q    <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            key_level_q <= key_level_d;
            missed_q    <= missed_d;
        end
    end

    assign jump_key       = pending_q;
    assign key_level      = key_level_q;
    assign missed_presses = missed_q;

endmodule

// File: tb/tb_jump_key_conditioner.sv
// Bench for jump_key_conditioner: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a run-length behavioural model.
module tb_jump_key_conditioner;

    localparam int D      = 4;
    localparam int MISS_W = 2;
    localparam int MMAX   = (1 << MISS_W) - 1;

    logic              proc_clk = 1'b0;
    logic              reset;
    logic              raw_key;
    logic              key_consume;
    logic              jump_key;
    logic              key_level;
    logic [MISS_W-1:0] missed_presses;

    int errors = 0;
    int checks = 0;

    jump_key_conditioner #(.DEBOUNCE_CYCLES(D), .MISS_W(MISS_W)) dut (
        .proc_clk      (proc_clk),
        .reset         (reset),
        .raw_key       (raw_key),
        .key_consume   (key_consume),
        .jump_key      (jump_key),
        .key_level     (key_level),
        .missed_presses(missed_presses)
    );

    always #5 proc_clk = ~proc_clk;

    // Model: raw_key reaches the debouncer two edges late; the debounced level flips once
    // D+1 consecutive samples disagree with it, and a rising flip is an accepted press.
    bit m_s1 = 0, m_s2 = 0, m_lvl = 0, m_pend = 0;
    int m_run = 0, m_missed = 0;

    always @(posedge proc_clk or posedge reset) begin
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_pend = 0; m_run = 0; m_missed = 0;
        end else begin
            bit fin, pressed;
            fin     = m_s2;
            m_s2    = m_s1;
            m_s1    = raw_key;
            pressed = 0;
            if (fin != m_lvl) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_lvl   = fin;
                    m_run   = 0;
                    pressed = fin;
                end
            end else begin
                m_run = 0;
            end
            if (pressed) begin
                if (m_pend && !key_consume && m_missed < MMAX) m_missed++;
                m_pend = 1;
            end else if (key_consume) begin
                m_pend = 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge proc_clk) begin
        chk("model_jump_key", int'(jump_key), int'(m_pend));
        chk("model_key_level", int'(key_level), int'(m_lvl));
        chk("model_missed", int'(missed_presses), m_missed);
    end

    // Apply inputs just after an edge, then advance to just after the next edge.
    task automatic cyc(input logic r, input logic kc);
        raw_key     = r;
        key_consume = kc;
        @(posedge proc_clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_jump"}, int'(jump_key), 0);
        chk({tag, "_level"}, int'(key_level), 0);
        chk({tag, "_missed"}, int'(missed_presses), 0);
    endtask

    initial begin
        bit seen;
        int lv, len;
        reset = 1'b1; raw_key = 1'b0; key_consume = 1'b0;
        #12;
        chk_zero("reset_state");
        @(posedge proc_clk); #1;
        reset = 1'b0;
        repeat (3) cyc(0, 0);

        // Clean press: outputs rise on the 7th edge with raw_key high; consume on edge 20.
        repeat (6) cyc(1, 0);
        chk("press_edge6_jump", int'(jump_key), 0);
        chk("press_edge6_level", int'(key_level), 0);
        cyc(1, 0);
        chk("press_edge7_jump", int'(jump_key), 1);
        chk("press_edge7_level", int'(key_level), 1);
        repeat (12) cyc(1, 0);
        chk("pending_held_jump", int'(jump_key), 1);
        cyc(1, 1);
        chk("consume_jump", int'(jump_key), 0);
        chk("consume_level", int'(key_level), 1);
        repeat (12) cyc(0, 0);
        chk("released_level", int'(key_level), 0);

        // Press bounce never reaches the debounced level.
        seen = 0;
        for (int i = 0; i < 18; i++) begin
            cyc((i < 8) ? ((i / 2) % 2 == 0) : 1'b0, 0);
            if (jump_key || key_level) seen = 1;
        end
        chk("bounce_seen", int'(seen), 0);
        chk("bounce_missed", int'(missed_presses), 0);

        // Five presses, never consumed: first sets pending, rest saturate the counter.
        for (int p = 0; p < 5; p++) begin
            repeat (10) cyc(1, 0);
            repeat (10) cyc(0, 0);
            chk("multi_jump", int'(jump_key), 1);
        end
        chk("multi_missed_sat", int'(missed_presses), 3);

        // Asynchronous reset clears everything without a clock edge.
        reset = 1'b1; #1;
        chk_zero("async_reset");
        cyc(0, 0);
        reset = 1'b0;
        repeat (3) cyc(0, 0);

        // Collision: consume on the exact acceptance edge of a second press.
        repeat (10) cyc(1, 0);
        repeat (10) cyc(0, 0);
        repeat (6) cyc(1, 0);
        cyc(1, 1);
        chk("collision_jump", int'(jump_key), 1);
        chk("collision_missed", int'(missed_presses), 0);
        cyc(1, 0);
        chk("collision_after_jump", int'(jump_key), 1);

        // Release bounce while held: level stays up, no extra press.
        seen = 0;
        repeat (2) begin cyc(0, 0); if (!key_level) seen = 1; end
        repeat (10) begin cyc(1, 0); if (!key_level) seen = 1; end
        chk("release_bounce_drop", int'(seen), 0);
        chk("release_bounce_missed", int'(missed_presses), 0);

        // Reset in WAIT_DOWN with cnt=2 while the button stays held: full re-debounce.
        repeat (10) cyc(0, 0);
        cyc(0, 1);
        repeat (5) cyc(1, 0);
        reset = 1'b1; #1;
        chk_zero("middebounce_reset");
        repeat (2) cyc(1, 0);
        reset = 1'b0;
        repeat (6) cyc(1, 0);
        chk("rearm_edge6_jump", int'(jump_key), 0);
        cyc(1, 0);
        chk("rearm_edge7_jump", int'(jump_key), 1);
        chk("rearm_edge7_level", int'(key_level), 1);

        // Random runs of levels with sporadic consumes and resets.
        for (int i = 0; i < 300; i++) begin
            lv  = $urandom_range(0, 1);
            len = $urandom_range(1, 12);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 299) == 0) begin
                    reset = 1'b1;
                    cyc(lv[0], 0);
                    reset = 1'b0;
                end else begin
                    cyc(lv[0], $urandom_range(0, 7) == 0);
                end
            end
        end

        @(negedge proc_clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jump_key_conditioner.md
JUMP_KEY_CONDITIONER -- requirements
Module: jump_key_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-sample count required to accept a level change (20 ms at 50 MHz); legal range 1 to 2^24-1.
REQ-002 SHALL have parameter MISS_W, default 8, width of the missed-press counter.
REQ-003 SHALL have port proc_clk  input  1  single clock for all logic; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port raw_key  input  1  asynchronous, bouncing push-button level, 1 = pressed.
REQ-006 SHALL have port key_consume  input  1  one-cycle pulse from the downstream interrupt controller marking that the pending press was sampled at a frame boundary.
REQ-007 SHALL have port jump_key  output  1  pending-press flag, fed to the interrupt controller's jump_key input.
REQ-008 SHALL have port key_level  output  1  debounced button level.
REQ-009 SHALL have port missed_presses  output  MISS_W  saturating count of presses accepted while a press was already pending.

Function
REQ-010 SHALL synchronize raw_key through a 2-flop chain (sync1, sync2); only sync2 drives the state machine.
REQ-011 SHALL implement states IDLE_UP, WAIT_DOWN, HELD_DOWN, WAIT_UP, plus a 24-bit counter cnt.
REQ-012 IDLE_UP: sync2=1 -> WAIT_DOWN with cnt<=0; otherwise stay.
REQ-013 WAIT_DOWN: sync2=0 -> IDLE_UP (bounce rejected, no press); else cnt==DEBOUNCE_CYCLES-1 -> HELD_DOWN; else cnt<=cnt+1.
REQ-014 HELD_DOWN: sync2=0 -> WAIT_UP with cnt<=0; otherwise stay.
REQ-015 WAIT_UP: sync2=1 -> HELD_DOWN (release bounce rejected, no new press); else cnt==DEBOUNCE_CYCLES-1 -> IDLE_UP; else cnt<=cnt+1.
REQ-016 key_level SHALL be 1 exactly in HELD_DOWN and WAIT_UP, registered.
REQ-017 An accepted press is the WAIT_DOWN->HELD_DOWN transition only; a press SHALL set pending on the same edge.
REQ-018 Latency: if raw_key is stable high from the edge where it is first sampled (edge 1), jump_key and key_level SHALL rise at edge DEBOUNCE_CYCLES+3.
REQ-019 jump_key SHALL equal pending and SHALL stay high through any number of frames until key_consume=1, clearing on that edge.
REQ-020 key_consume while pending=0 SHALL have no effect.
REQ-021 Simultaneous press acceptance and key_consume: pending SHALL remain 1 (the new press wins) and missed_presses SHALL NOT increment.
REQ-022 Press accepted while pending=1 and no key_consume SHALL increment missed_presses by 1, saturating at 2^MISS_W-1 (no wrap).
REQ-023 Holding the button indefinitely SHALL produce exactly one accepted press.
REQ-024 cnt SHALL never exceed DEBOUNCE_CYCLES-1; no arithmetic overflow.

Reset
REQ-025 reset=1 SHALL immediately force sync1=sync2=0, state IDLE_UP, cnt=0, pending=0, jump_key=0, key_level=0, missed_presses=0, regardless of clock.
REQ-026 Reset asserted mid-debounce or mid-hold SHALL discard the in-progress press; after release, a button still held SHALL be re-debounced from IDLE_UP, with a full DEBOUNCE_CYCLES+3 latency.

Verification (DEBOUNCE_CYCLES=4, MISS_W=2)
REQ-027 Clean press: raw_key 0->1 held -> jump_key=1 and key_level=1 at edge 7; key_consume pulse at edge 20 -> jump_key=0 at edge 20, key_level stays 1.
REQ-028 Bounce: raw_key toggles 1,0,1,0 every 2 cycles, then stays 0 -> jump_key and key_level never assert, missed_presses=0.
REQ-029 Missed presses: five clean press/release cycles with no key_consume -> jump_key=1 throughout, missed_presses=3 (saturated).
REQ-030 Collision: key_consume pulsed on the exact edge of a second press acceptance -> jump_key stays 1, missed_presses unchanged.
REQ-031 Reset mid-operation: reset pulsed while in WAIT_DOWN with cnt=2 and raw_key held 1 -> all outputs 0 immediately; jump_key re-asserts 7 edges after reset deasserts.
REQ-032 Release bounce: while held, raw_key drops to 0 for 2 cycles, then returns to 1 -> key_level stays 1, no second press, missed_presses unchanged.
